spi_slave_frame_buffer: RTL and testbench
=========================================

Name: spi_slave_frame_buffer

Overview:
- Parametrised SPI slave processing unit, the successor to our single-word SPI slave PU.
- Exchanges a frame of up to WORDS words of DATA_WIDTH bits per chip-select assertion.
- Supports all four SPI modes and either bit order; the mode and bit order are fixed per instance.
- System side writes a TX buffer and reads a committed RX buffer; SPI pins are oversampled in the clk domain.

Parameters:
DATA_WIDTH, 8, bits per SPI word
WORDS, 4, words per frame buffer (>=1)
CPOL, 0, sclk idle level
CPHA, 0, 0: sample on leading edge, shift on trailing; 1: shift on leading, sample on trailing
MSB_FIRST, 1, 1: MSB of each word first on the wire; 0: LSB first
AW, $clog2(WORDS) (min 1), buffer address width

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
tx_we  in  1  write strobe for the TX buffer
tx_addr  in  AW  TX word index
tx_data  in  DATA_WIDTH  TX word
rx_addr  in  AW  RX word index
rx_data  out  DATA_WIDTH  registered RX buffer read, 1-cycle latency
words_rx  out  $clog2(WORDS+1)  complete words in the last committed frame
overrun  out  1  last frame clocked more than WORDS*DATA_WIDTH bits
frame_done  out  1  one-cycle pulse when a frame is committed
ready  out  1  high only in IDLE
miso  out  1  slave data out
mosi  in  1  master data in
sclk  in  1  SPI clock
cs  in  1  chip select, active-low

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values: all outputs 0, TX buffer, RX buffer and shadow all 0, state WAIT_CS_HIGH.
- Synchronisers: sclk, cs and mosi each pass through 2 flops; edges are detected on the 2nd stage against a 3rd-stage copy.
- sclk constraint: high and low phases must each be >=4 clk cycles.
- Leading edge: the sclk transition away from CPOL. Trailing edge: the transition back to CPOL.
- WAIT_CS_HIGH: entered from reset; waits for synchronised cs=1, then goes to IDLE. A frame already in progress at reset release is ignored entirely.
- IDLE (ready=1): on synchronised cs falling, snapshot the TX buffer into the TX shadow, clear the bit and word counters, go to ACTIVE.
  - If CPHA=0, miso presents word 0 / bit 0 from the cycle after entry.
- ACTIVE, sample edge: shift the synchronised mosi into the working word (MSB_FIRST selects shift direction) and increment the bit counter.
  - After DATA_WIDTH samples, write the word to working RX slot word_idx (if word_idx<WORDS), increment word_idx and wrap the bit counter to 0.
  - If a sample occurs with word_idx>=WORDS, set the internal overrun flag and discard the bit.
- ACTIVE, shift edge: advance miso to the next bit.
  - If CPHA=1, the first leading edge presents word 0 / bit 0.
  - With word_idx>=WORDS, miso=0.
- ACTIVE, cs rises: go to DONE. Edge order in one cycle: a cs rise takes priority, and a same-cycle sclk edge is ignored.
- DONE (one cycle):
  - Copy completed working RX slots 0..min(word_idx,WORDS)-1 into the RX shadow; shadow slots beyond that keep their old values.
  - A partial word is discarded.
  - words_rx=min(word_idx,WORDS); overrun=internal flag.
  - frame_done=1 during DONE only. Next state is IDLE.
- frame_done latency: frame_done is high in the cycle following the 3rd rising clk edge that samples cs high on the pin.
- miso=0 outside ACTIVE.
- TX writes are accepted in any state and affect only the next snapshot. A tx_we in the same cycle as the snapshot is not included in that snapshot.
- rx_data=shadow[rx_addr] registered each cycle. Out-of-range rx_addr (>=WORDS) returns 0; out-of-range tx_addr writes are ignored.
- words_rx and overrun hold until the next DONE.
- Async reset mid-frame: all state is cleared immediately and the device rejoins only after cs has been seen high.

Test Plan:
1. Mode 0, MSB first, WORDS=4. TX={A5,3C,FF,00}; master sends 11,22,33,44 -> master reads A5,3C,FF,00; rx[0..3]=11,22,33,44; words_rx=4; overrun=0; frame_done high exactly 1 cycle; ready low during the frame.
2. Partial frame: after test 1, master sends 2 words (55,66) plus 3 bits, then raises cs -> words_rx=2, rx={55,66,33,44}, overrun=0.
3. Overrun: master sends 5 words -> words_rx=4, overrun=1, 5th word seen by the master is 00; the next 1-word frame clears overrun to 0.
4. Instance with CPOL=1, CPHA=1, MSB_FIRST=0: TX[0]=01, master sends 80 -> first miso bit 1 then seven 0s; rx[0]=80.
5. tx_we to addr 0 with value 77 mid-frame -> the current frame still sends A5; the next frame sends 77. tx_we with addr 0 coinciding with the snapshot cycle -> that snapshot keeps the old word.
6. rst low after 4 bits with cs low, released while cs is still low, master continues -> no frame_done, miso=0, ready=0. After cs high then a fresh 1-word frame -> normal capture, words_rx=1.

Source files
------------

// File: rtl/spi_slave_frame_buffer.sv
// SPI slave frame buffer. It exchanges up to WORDS words of DATA_WIDTH bits per chip-select
// assertion. The SPI pins are oversampled in the clk domain. The system side writes a TX buffer
// and reads back the RX buffer committed at the end of each frame.
module spi_slave_frame_buffer #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned WORDS      = 4,
   parameter bit          CPOL       = 1'b0,
   parameter bit          CPHA       = 1'b0,
   parameter bit          MSB_FIRST  = 1'b1,
   parameter int unsigned AW         = (WORDS > 1) ? $clog2(WORDS) : 1,
   localparam int unsigned WCW       = $clog2(WORDS + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  tx_we,
   input  logic [AW-1:0]         tx_addr,
   input  logic [DATA_WIDTH-1:0] tx_data,
   input  logic [AW-1:0]         rx_addr,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic [WCW-1:0]        words_rx,
   output logic                  overrun,
   output logic                  frame_done,
   output logic                  ready,
   output logic                  miso,
   input  logic                  mosi,
   input  logic                  sclk,
   input  logic                  cs
);

   localparam int unsigned BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [BW-1:0]  BIT_LAST = BW'(DATA_WIDTH - 1);
   localparam logic [WCW-1:0] WORDS_W  = WCW'(WORDS);
   localparam logic [AW:0]    WORDS_A  = (AW + 1)'(WORDS);

   typedef enum logic [1:0] {StWaitCsHigh, StIdle, StActive, StDone} state_e;

   state_e                r_state;
   state_e                w_state_next;
   logic                  w_start;
   logic                  w_commit;

   logic [2:0]            r_sclk_sync;
   logic [2:0]            r_cs_sync;
   logic [1:0]            r_mosi_sync;

   logic [DATA_WIDTH-1:0] r_tx_buf    [WORDS];
   logic [DATA_WIDTH-1:0] r_tx_shadow [WORDS];
   logic [DATA_WIDTH-1:0] r_rx_work   [WORDS];
   logic [DATA_WIDTH-1:0] r_rx_shadow [WORDS];

   logic [DATA_WIDTH-1:0] r_rx_shift;
   logic [DATA_WIDTH-1:0] w_rx_shift_next;
   logic [BW-1:0]         r_bit_cnt;
   logic [WCW-1:0]        r_word_idx;
   logic                  r_ovf;
   logic [BW-1:0]         r_tx_bit;
   logic [WCW-1:0]        r_tx_word;
   logic                  r_tx_started;
   logic [BW-1:0]         w_tx_bit_idx;

   logic [DATA_WIDTH-1:0] r_rx_data;
   logic [WCW-1:0]        r_words_rx;
   logic                  r_overrun;

   logic                  w_sclk_rise;
   logic                  w_sclk_fall;
   logic                  w_lead;
   logic                  w_trail;
   logic                  w_cs_rise;
   logic                  w_do_sample;
   logic                  w_do_shift;
   logic                  w_miso;

   // Pin synchronisers; the 3rd sclk/cs stage exists only for edge detection
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sclk_sync <= '0;
         r_cs_sync   <= '0;
         r_mosi_sync <= '0;
      end else begin
         r_sclk_sync <= {r_sclk_sync[1:0], sclk};
         r_cs_sync   <= {r_cs_sync[1:0], cs};
         r_mosi_sync <= {r_mosi_sync[0], mosi};
      end
   end

   // Edge decode: leading edge leaves CPOL, CPHA picks which edge samples and which shifts
   always_comb begin
      w_sclk_rise = r_sclk_sync[1] & ~r_sclk_sync[2];
      w_sclk_fall = ~r_sclk_sync[1] & r_sclk_sync[2];
      w_lead      = CPOL ? w_sclk_fall : w_sclk_rise;
      w_trail     = CPOL ? w_sclk_rise : w_sclk_fall;
      w_cs_rise   = r_cs_sync[1] & ~r_cs_sync[2];
      // A cs rise wins over any sclk edge in the same cycle
      w_do_sample = (r_state == StActive) & ~w_cs_rise & (CPHA ? w_trail : w_lead);
      w_do_shift  = (r_state == StActive) & ~w_cs_rise & (CPHA ? w_lead : w_trail);
      w_rx_shift_next = MSB_FIRST ? {r_rx_shift[DATA_WIDTH-2:0], r_mosi_sync[1]}
                                  : {r_mosi_sync[1], r_rx_shift[DATA_WIDTH-1:1]};
   end

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= StWaitCsHigh;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic and state-decoded strobes/outputs
   always_comb begin
      w_state_next = r_state;
      w_start      = 1'b0;
      w_commit     = 1'b0;
      ready        = 1'b0;
      frame_done   = 1'b0;
      unique case (r_state)
         StWaitCsHigh: begin
            if (r_cs_sync[1]) w_state_next = StIdle;
         end
         StIdle: begin
            ready = 1'b1;
            // IDLE is only reached with cs high, so a low level here is the falling edge;
            // the level check also catches a fall that landed during DONE.
            if (!r_cs_sync[1]) begin
               w_start      = 1'b1;
               w_state_next = StActive;
            end
         end
         StActive: begin
            if (w_cs_rise) begin
               w_commit     = 1'b1;
               w_state_next = StDone;
            end
         end
         StDone: begin
            frame_done   = 1'b1;
            w_state_next = StIdle;
         end
         default: w_state_next = StWaitCsHigh;
      endcase
   end

   // System-side TX buffer writes; out-of-range addresses are dropped
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < WORDS; i++) r_tx_buf[i] <= '0;
      end else if (tx_we && ({1'b0, tx_addr} < WORDS_A)) begin
         r_tx_buf[tx_addr] <= tx_data;
      end
   end

   // Frame datapath: snapshot, RX capture, TX bit pointer and commit into the RX shadow
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < WORDS; i++) begin
            r_tx_shadow[i] <= '0;
            r_rx_work[i]   <= '0;
            r_rx_shadow[i] <= '0;
         end
         r_rx_shift   <= '0;
         r_bit_cnt    <= '0;
         r_word_idx   <= '0;
         r_ovf        <= 1'b0;
         r_tx_bit     <= '0;
         r_tx_word    <= '0;
         r_tx_started <= 1'b0;
         r_words_rx   <= '0;
         r_overrun    <= 1'b0;
      end else begin
         if (w_start) begin
            for (int i = 0; i < WORDS; i++) r_tx_shadow[i] <= r_tx_buf[i];
            r_rx_shift   <= '0;
            r_bit_cnt    <= '0;
            r_word_idx   <= '0;
            r_ovf        <= 1'b0;
            r_tx_bit     <= '0;
            r_tx_word    <= '0;
            // With CPHA=1 nothing is driven until the first leading edge
            r_tx_started <= !CPHA;
         end
         if (w_do_sample) begin
            if (r_word_idx < WORDS_W) begin
               r_rx_shift <= w_rx_shift_next;
               if (r_bit_cnt == BIT_LAST) begin
                  r_rx_work[r_word_idx[AW-1:0]] <= w_rx_shift_next;
                  r_word_idx <= r_word_idx + 1'b1;
                  r_bit_cnt  <= '0;
               end else begin
                  r_bit_cnt <= r_bit_cnt + 1'b1;
               end
            end else begin
               r_ovf <= 1'b1;
            end
         end
         if (w_do_shift) begin
            if (!r_tx_started) begin
               r_tx_started <= 1'b1;
            end else if (r_tx_word < WORDS_W) begin
               if (r_tx_bit == BIT_LAST) begin
                  r_tx_bit  <= '0;
                  r_tx_word <= r_tx_word + 1'b1;
               end else begin
                  r_tx_bit <= r_tx_bit + 1'b1;
               end
            end
         end
         if (w_commit) begin
            // Only completed words are copied; word_idx saturates at WORDS
            for (int i = 0; i < WORDS; i++) begin
               if (WCW'(i) < r_word_idx) r_rx_shadow[i] <= r_rx_work[i];
            end
            r_words_rx <= r_word_idx;
            r_overrun  <= r_ovf;
         end
      end
   end

   // Registered RX shadow read port
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rx_data <= '0;
      end else if ({1'b0, rx_addr} < WORDS_A) begin
         r_rx_data <= r_rx_shadow[rx_addr];
      end else begin
         r_rx_data <= '0;
      end
   end

   // MISO bit select; driven low outside ACTIVE and once the TX frame is exhausted
   always_comb begin
      w_tx_bit_idx = MSB_FIRST ? (BIT_LAST - r_tx_bit) : r_tx_bit;
      w_miso       = 1'b0;
      if ((r_state == StActive) && r_tx_started && (r_tx_word < WORDS_W)) begin
         w_miso = r_tx_shadow[r_tx_word[AW-1:0]][w_tx_bit_idx];
      end
   end

   assign miso     = w_miso;
   assign rx_data  = r_rx_data;
   assign words_rx = r_words_rx;
   assign overrun  = r_overrun;

endmodule

// File: tb/tb_spi_slave_frame_buffer.sv
// Bench for spi_slave_frame_buffer. Two instances are used: mode 0 MSB-first, and
// CPOL=1/CPHA=1 LSB-first. A bit-level SPI master drives the pins. A frame-level reference
// model predicts the MISO words, the RX buffer contents and the words_rx/overrun results.
// Commit results are checked by a monitor that pops expectations from a queue.
module tb_spi_slave_frame_buffer;

   localparam int HALF = 6;

   typedef struct {
      logic       sel;
      logic [2:0] words;
      logic       ovf;
   } expect_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       tx_we;
   logic [1:0] tx_addr;
   logic [7:0] tx_data;
   logic [1:0] rx_addr;
   logic       sel;
   logic       m_sclk, m_cs, m_mosi, m_cpol, m_cpha, m_msb;

   logic [7:0] rx_data0, rx_data1;
   logic [2:0] words_rx0, words_rx1;
   logic       overrun0, overrun1, fd0, fd1, ready0, ready1, miso0, miso1;

   wire sclk0 = sel ? 1'b0 : m_sclk;
   wire cs0   = sel ? 1'b1 : m_cs;
   wire sclk1 = sel ? m_sclk : 1'b1;
   wire cs1   = sel ? m_cs : 1'b1;
   wire we0   = tx_we & ~sel;
   wire we1   = tx_we & sel;
   wire       w_miso    = sel ? miso1 : miso0;
   wire       w_ready   = sel ? ready1 : ready0;
   wire [7:0] w_rx_data = sel ? rx_data1 : rx_data0;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fd     = 0;
   expect_t exp_q [$];
   expect_t m_e;
   logic       fd_prev;
   logic [7:0] exp_tx [2][4];
   logic [7:0] exp_rx [2][4];
   logic [7:0] mo [6];

   always #5 clk = ~clk;

   spi_slave_frame_buffer #(
      .DATA_WIDTH(8), .WORDS(4), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b1)
   ) u_dut0 (
      .clk(clk), .rst(rst), .tx_we(we0), .tx_addr(tx_addr), .tx_data(tx_data),
      .rx_addr(rx_addr), .rx_data(rx_data0), .words_rx(words_rx0), .overrun(overrun0),
      .frame_done(fd0), .ready(ready0), .miso(miso0), .mosi(m_mosi), .sclk(sclk0), .cs(cs0)
   );

   spi_slave_frame_buffer #(
      .DATA_WIDTH(8), .WORDS(4), .CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b0)
   ) u_dut1 (
      .clk(clk), .rst(rst), .tx_we(we1), .tx_addr(tx_addr), .tx_data(tx_data),
      .rx_addr(rx_addr), .rx_data(rx_data1), .words_rx(words_rx1), .overrun(overrun1),
      .frame_done(fd1), .ready(ready1), .miso(miso1), .mosi(m_mosi), .sclk(sclk1), .cs(cs1)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic clear_model();
      for (int s = 0; s < 2; s++)
         for (int i = 0; i < 4; i++) begin
            exp_tx[s][i] = 8'h00;
            exp_rx[s][i] = 8'h00;
         end
   endtask

   task automatic set_mode(input logic s);
      sel    = s;
      m_cpol = s;
      m_cpha = s;
      m_msb  = !s;
      m_sclk = s;
      m_cs   = 1'b1;
      wait_clk(4);
   endtask

   task automatic tx_write(input int addr, input logic [7:0] data);
      tx_we   = 1'b1;
      tx_addr = 2'(addr);
      tx_data = data;
      wait_clk(1);
      tx_we = 1'b0;
      exp_tx[sel][addr] = data;
   endtask

   // One SPI bit as the master sees it; ibit is sampled on the master's sampling edge
   task automatic spi_bit(input logic obit, output logic ibit);
      if (!m_cpha) begin
         m_mosi = obit;
         wait_clk(HALF);
         ibit   = w_miso;
         m_sclk = ~m_cpol;
         wait_clk(HALF);
         m_sclk = m_cpol;
      end else begin
         m_sclk = ~m_cpol;
         m_mosi = obit;
         wait_clk(HALF);
         ibit   = w_miso;
         m_sclk = m_cpol;
         wait_clk(HALF);
      end
   endtask

   // Full frame of nbits; optionally writes TX[0] in the cycle the DUT takes its snapshot
   task automatic xfer(input int nbits, input logic [7:0] mosi_w [6],
                       input bit snap_wr, input logic [7:0] snap_val);
      logic [7:0] snap [4];
      logic [7:0] mi [6];
      logic       b;
      int         full, nw;
      expect_t    e;
      for (int i = 0; i < 4; i++) snap[i] = exp_tx[sel][i];
      for (int i = 0; i < 6; i++) mi[i] = 8'h00;
      m_cs = 1'b0;
      wait_clk(2);
      if (snap_wr) tx_write(0, snap_val);
      wait_clk(8);
      for (int bi = 0; bi < nbits; bi++) begin
         int w, p;
         w = bi / 8;
         p = m_msb ? 7 - (bi % 8) : bi % 8;
         spi_bit(mosi_w[w][p], b);
         mi[w][p] = b;
         if (bi == 0) chk("ready_in_frame", 32'(w_ready), 32'd0);
      end
      wait_clk(HALF);
      full = nbits / 8;
      nw   = (full < 4) ? full : 4;
      for (int i = 0; i < nw; i++) exp_rx[sel][i] = mosi_w[i];
      e.sel   = sel;
      e.words = 3'(nw);
      e.ovf   = (nbits > 32);
      exp_q.push_back(e);
      m_cs = 1'b1;
      for (int w = 0; w < full && w < 6; w++)
         chk($sformatf("miso_word%0d", w), 32'(mi[w]), 32'((w < 4) ? snap[w] : 8'h00));
      wait_clk(6);
      for (int i = 0; i < 4; i++) begin
         rx_addr = 2'(i);
         wait_clk(1);
         chk($sformatf("rx_slot%0d", i), 32'(w_rx_data), 32'(exp_rx[sel][i]));
      end
      wait_clk(4);
   endtask

   // Monitor: each frame_done pops one expectation; the pulse must be exactly one cycle
   always @(negedge clk) begin
      if (!rst) begin
         fd_prev = 1'b0;
      end else begin
         if (fd_prev) chk("frame_done_width", 32'(fd0 | fd1), 32'd0);
         if (fd0 | fd1) begin
            n_fd++;
            if (exp_q.size() == 0) begin
               n_checks++;
               $display("FAIL unexpected_frame_done: got 1 expected 0 at %0t", $time);
            end else begin
               m_e = exp_q.pop_front();
               chk("frame_done_dut", 32'(fd1), 32'(m_e.sel));
               chk("words_rx", 32'(fd1 ? words_rx1 : words_rx0), 32'(m_e.words));
               chk("overrun", 32'(fd1 ? overrun1 : overrun0), 32'(m_e.ovf));
            end
         end
         fd_prev = fd0 | fd1;
      end
   end

   initial begin
      logic b;
      int   fd_before;
      rst = 1'b0; tx_we = 1'b0; tx_addr = '0; tx_data = '0; rx_addr = '0; sel = 1'b0;
      m_cs = 1'b1; m_sclk = 1'b0; m_mosi = 1'b0; m_cpol = 1'b0; m_cpha = 1'b0; m_msb = 1'b1;
      clear_model();
      wait_clk(3);
      chk("rst_rx_data", 32'(rx_data0), 32'd0);
      chk("rst_words_rx", 32'(words_rx0), 32'd0);
      chk("rst_overrun", 32'(overrun0), 32'd0);
      chk("rst_frame_done", 32'(fd0 | fd1), 32'd0);
      chk("rst_ready", 32'({ready1, ready0}), 32'd0);
      chk("rst_miso", 32'({miso1, miso0}), 32'd0);
      rst = 1'b1;
      wait_clk(6);
      chk("ready_idle", 32'({ready1, ready0}), 32'd3);

      // Full frame, mode 0
      set_mode(1'b0);
      tx_write(0, 8'hA5); tx_write(1, 8'h3C); tx_write(2, 8'hFF); tx_write(3, 8'h00);
      mo = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00};
      xfer(32, mo, 1'b0, 8'h00);
      // Partial frame: two words plus three bits
      mo = '{8'h55, 8'h66, 8'hE0, 8'h00, 8'h00, 8'h00};
      xfer(19, mo, 1'b0, 8'h00);
      // Overrun with five words, then a one-word frame clears it
      mo = '{8'h9A, 8'hBC, 8'hDE, 8'hF1, 8'h23, 8'h00};
      xfer(40, mo, 1'b0, 8'h00);
      mo = '{8'h42, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      xfer(8, mo, 1'b0, 8'h00);

      // TX write mid-frame, then a write coinciding with the snapshot
      mo = '{8'h5C, 8'hC5, 8'h00, 8'h00, 8'h00, 8'h00};
      fork
         xfer(16, mo, 1'b0, 8'h00);
         begin
            wait_clk(40);
            tx_write(0, 8'h77);
         end
      join
      mo = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      xfer(8, mo, 1'b1, 8'h88);
      xfer(8, mo, 1'b0, 8'h00);

      // CPOL=1, CPHA=1, LSB first
      set_mode(1'b1);
      tx_write(0, 8'h01);
      mo = '{8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      xfer(8, mo, 1'b0, 8'h00);

      // Reset in the middle of a frame
      set_mode(1'b0);
      fd_before = n_fd;
      m_cs = 1'b0;
      wait_clk(10);
      for (int i = 0; i < 4; i++) spi_bit(1'($urandom_range(0, 1)), b);
      rst = 1'b0;
      wait_clk(3);
      clear_model();
      chk("midrst_words_rx", 32'(words_rx0), 32'd0);
      chk("midrst_miso", 32'(miso0), 32'd0);
      rst = 1'b1;
      wait_clk(2);
      for (int i = 0; i < 12; i++) begin
         spi_bit(1'b1, b);
         chk("miso_after_rst", 32'(b), 32'd0);
      end
      chk("ready_after_rst", 32'(ready0), 32'd0);
      wait_clk(HALF);
      m_cs = 1'b1;
      wait_clk(20);
      chk("no_frame_done_after_rst", 32'(n_fd), 32'(fd_before));
      tx_write(0, 8'h5A);
      mo = '{8'hC3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      xfer(8, mo, 1'b0, 8'h00);

      // Randomised frames across both instances
      for (int it = 0; it < 14; it++) begin
         set_mode(1'($urandom_range(0, 1)));
         for (int k = 0; k < int'($urandom_range(0, 3)); k++)
            tx_write(int'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
         for (int i = 0; i < 6; i++) mo[i] = 8'($urandom_range(0, 255));
         xfer(int'($urandom_range(0, 44)), mo, 1'b0, 8'h00);
      end

      for (int i = 0; i < 50 && exp_q.size() != 0; i++) wait_clk(1);
      chk("pending_frames", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
